// File: rtl/exins_pkg.sv
// Shared definitions for the external-instruction fetch bridge:
// FSM state encoding, the NOP returned on range errors and the byte-lane index type.
package exins_pkg;

  typedef logic [2:0] stateT;

  localparam stateT IDLE  = 3'd0;
  localparam stateT ISSUE = 3'd1;
  localparam stateT WAIT  = 3'd2;
  localparam stateT DONE  = 3'd3;
  localparam stateT HIT   = 3'd4;
  localparam stateT ERR   = 3'd5;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef logic [1:0] byteIdxT;

endpackage

// File: rtl/exins_fetch_bridge_if.sv
// Core-side fetch handshake plus byte-wide ROM port of the fetch bridge.
// slave = bridge side, master = core/ROM side.
interface exins_fetch_bridge_if #(
  parameter int ROM_AW = 12
);
  logic              exIns_ren;
  logic [31:0]       exIns_addr;
  logic              exIns_valid;
  logic [31:0]       exIns_in;
  logic              fetch_err;
  logic              flush;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_rdata;

  modport slave (
    input  exIns_ren, exIns_addr, flush, rom_rdata,
    output exIns_valid, exIns_in, fetch_err, rom_en, rom_addr
  );

  modport master (
    output exIns_ren, exIns_addr, flush, rom_rdata,
    input  exIns_valid, exIns_in, fetch_err, rom_en, rom_addr
  );
endinterface

// File: rtl/exins_word_asm.sv
// Four-lane byte register: writes din into lane idx (lane 0 = bits [7:0]),
// cleared at the start of every miss.
module exins_word_asm
  import exins_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  byteIdxT     idx,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
    end else if (we) begin
      word[{idx, 3'b000} +: 8] <= din;
    end
  end

endmodule

// File: rtl/exins_fetch_bridge.sv
// Fetch bridge: assembles four ROM bytes into an instruction word for the core,
// with a one-entry last-word buffer for repeated fetches.
// IDLE wait for ren | ISSUE strobe one byte | WAIT ROM latency | DONE return miss | HIT return buffer | ERR return NOP
module exins_fetch_bridge
  import exins_pkg::*;
#(
  parameter int ROM_AW  = 12,
  parameter int ROM_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  exins_fetch_bridge_if.slave bus
);

  localparam int CW = $clog2(ROM_LAT + 1);

  stateT             state;
  logic [ROM_AW-3:0] addrQ;
  logic [ROM_AW-3:0] tag;
  logic              tagValid;
  logic              flushSeen;
  byteIdxT           byteIdx;
  logic [CW-1:0]     cnt;
  logic [31:0]       bufWord;
  logic [31:0]       insHold;
  logic [31:0]       asmWord;
  logic              outOfRange;
  logic              tagHit;
  logic              missStart;
  logic              byteDone;
  logic              unusedAddrBits;

  assign outOfRange     = |bus.exIns_addr[31:ROM_AW];
  assign tagHit         = tagValid && (tag == bus.exIns_addr[ROM_AW-1:2]) && !bus.flush;
  assign missStart      = (state == IDLE) && bus.exIns_ren && !outOfRange && !tagHit;
  assign byteDone       = (state == WAIT) && (cnt == CW'(1));
  assign unusedAddrBits = ^bus.exIns_addr[1:0];

  exins_word_asm u_wordAsm (
    .clk  (clk),
    .rst  (rst),
    .clr  (missStart),
    .we   (byteDone),
    .idx  (byteIdx),
    .din  (bus.rom_rdata),
    .word (asmWord)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      tag       <= '0;
      tagValid  <= 1'b0;
      flushSeen <= 1'b0;
      byteIdx   <= '0;
      cnt       <= '0;
      bufWord   <= '0;
      insHold   <= '0;
    end else begin
      if (bus.flush) tagValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.exIns_ren) begin
            if (outOfRange) begin
              state <= ERR;
            end else if (tagHit) begin
              state <= HIT;
            end else begin
              addrQ     <= bus.exIns_addr[ROM_AW-1:2];
              byteIdx   <= '0;
              flushSeen <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.flush) flushSeen <= 1'b1;
          cnt   <= CW'(ROM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          if (bus.flush) flushSeen <= 1'b1;
          cnt <= cnt - 1'b1;
          if (byteDone) begin
            if (byteIdx == 2'd3) begin
              state <= DONE;
            end else begin
              byteIdx <= byteIdx + 2'd1;
              state   <= ISSUE;
            end
          end
        end
        DONE: begin
          // a flush seen anywhere in the fetch means the word may be stale
          tag      <= addrQ;
          tagValid <= !(flushSeen || bus.flush);
          bufWord  <= asmWord;
          insHold  <= asmWord;
          state    <= IDLE;
        end
        HIT: begin
          insHold <= bufWord;
          state   <= IDLE;
        end
        ERR: begin
          insHold <= NOP;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_en      = (state == ISSUE);
  assign bus.rom_addr    = {addrQ, byteIdx};
  assign bus.exIns_valid = (state == DONE) || (state == HIT) || (state == ERR);
  assign bus.fetch_err   = (state == ERR);
  assign bus.exIns_in    = (state == DONE) ? asmWord :
                           (state == HIT)  ? bufWord :
                           (state == ERR)  ? NOP     : insHold;

endmodule

// File: tb/tb_exins_fetch_bridge.sv
// Directed plus randomized fetch sequences against a byte-ROM model and a
// transaction-level expectation of latency, data, error flag and ROM strobes.
module tb_exins_fetch_bridge;
  import exins_pkg::*;

  localparam int ROM_AW   = 12;
  localparam int ROM_LAT  = 2;
  localparam int MISS_LAT = 4 * ROM_LAT + 5;
  localparam int BUDGET   = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exins_fetch_bridge_if #(.ROM_AW(ROM_AW)) bus ();

  exins_fetch_bridge #(.ROM_AW(ROM_AW), .ROM_LAT(ROM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rom [2**ROM_AW];
  logic [7:0] pipe [ROM_LAT];

  // byte appears exactly ROM_LAT cycles after the strobe; garbage otherwise
  always @(posedge clk) begin
    pipe[0] <= bus.rom_en ? rom[bus.rom_addr] : 8'($urandom);
    for (int i = ROM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign bus.rom_rdata = pipe[ROM_LAT-1];

  int vectors = 0;
  int errs    = 0;

  logic        mTagValid;
  logic [29:0] mTag;
  logic [31:0] mWord;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, "_rom_en"}, 32'(bus.rom_en), 32'd0);
    check({tag, "_valid"}, 32'(bus.exIns_valid), 32'd0);
    check({tag, "_err"}, 32'(bus.fetch_err), 32'd0);
    check({tag, "_ins"}, bus.exIns_in, 32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
  endtask

  // flushAt: -1 none, 0 with the request, n>0 during cycle T+n
  task automatic fetch(input logic [31:0] addr, input int flushAt);
    int          base, expLat, n, gotLat;
    logic [31:0] expWord, gotWord;
    logic        gotErr, inRange, hit, flushInFetch;
    int          romCyc[$];
    int          romAdr[$];

    inRange = (addr >> ROM_AW) == 0;
    hit     = inRange && mTagValid && (mTag == addr[31:2]) && (flushAt != 0);
    base    = int'(addr[ROM_AW-1:0]) & ~3;
    expLat  = (inRange && !hit) ? MISS_LAT : 1;
    if (!inRange)  expWord = 32'h00000013;
    else if (hit)  expWord = mWord;
    else           expWord = {rom[base+3], rom[base+2], rom[base+1], rom[base]};

    @(posedge clk); #1;
    bus.exIns_ren  = 1'b1;
    bus.exIns_addr = addr;
    bus.flush      = (flushAt == 0);
    n       = 0;
    gotLat  = -1;
    gotWord = '0;
    gotErr  = 1'b0;
    while (gotLat < 0 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      bus.flush = (flushAt == n);
      if (bus.rom_en) begin
        romCyc.push_back(n);
        romAdr.push_back(int'(bus.rom_addr));
      end
      if (bus.exIns_valid) begin
        gotLat  = n;
        gotWord = bus.exIns_in;
        gotErr  = bus.fetch_err;
      end
    end
    bus.exIns_ren = 1'b0;
    bus.flush     = 1'b0;

    check("latency", gotLat, expLat);
    check("data", gotWord, expWord);
    check("fetch_err", 32'(gotErr), 32'(!inRange));
    check("rom_en_count", romCyc.size(), (inRange && !hit) ? 4 : 0);
    if (romCyc.size() == 4 && inRange && !hit) begin
      for (int i = 0; i < 4; i++) begin
        check("rom_addr", romAdr[i], base + i);
        check("rom_en_cycle", romCyc[i], 1 + i * (ROM_LAT + 1));
      end
    end

    flushInFetch = (flushAt >= 1) && (flushAt <= expLat);
    if (flushAt == 0) mTagValid = 1'b0;
    if (inRange && !hit) begin
      mTagValid = !flushInFetch;
      mTag      = addr[31:2];
      mWord     = expWord;
    end else if (flushInFetch) begin
      mTagValid = 1'b0;
    end
  endtask

  initial begin
    int          sel, r, fl, nValid;
    logic [31:0] a;

    rst            = 1'b1;
    bus.exIns_ren  = 1'b0;
    bus.exIns_addr = '0;
    bus.flush      = 1'b0;
    for (int i = 0; i < 2**ROM_AW; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < ROM_LAT; i++) pipe[i] = '0;
    rom[0] = 8'h93; rom[1] = 8'h00; rom[2] = 8'h10; rom[3] = 8'h00;
    mTagValid = 1'b0;
    mTag      = '0;
    mWord     = '0;

    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    rst = 1'b0;

    // miss, then the test-plan word itself
    fetch(32'h0, -1);
    check("tp_word", mWord, 32'h00100093);
    fetch(32'h2, -1);
    fetch(32'h0, 0);
    fetch(32'h0, -1);
    fetch(32'h00001000, -1);
    fetch(32'h0, 5);
    fetch(32'h0, -1);

    // reset during the first WAIT cycle of byte 2
    @(posedge clk); #1;
    bus.exIns_ren  = 1'b1;
    bus.exIns_addr = 32'h8;
    repeat (2 * (ROM_LAT + 1) + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.exIns_ren = 1'b0;
    checkQuiet("midreset");
    mTagValid = 1'b0;
    nValid = 0;
    repeat (MISS_LAT + 2) begin
      @(posedge clk); #1;
      if (bus.exIns_valid || bus.rom_en) nValid++;
    end
    check("post_reset_activity", nValid, 0);

    fetch(32'h4, -1);
    fetch(32'h8, -1);
    fetch(32'h8, -1);

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4)       a = 32'(4 * sel + $urandom_range(0, 3));
      else if (sel == 4) a = 32'($urandom_range(0, 2**ROM_AW - 1));
      else               a = 32'($urandom) | 32'h00001000;
      r = $urandom_range(0, 9);
      if (r < 7)       fl = -1;
      else if (r == 7) fl = 0;
      else             fl = $urandom_range(1, MISS_LAT);
      fetch(a, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/exins_fetch_bridge.md
Name: exins_fetch_bridge

Overview:
- Sits directly upstream of core's external instruction port.
- Services each exIns_ren/exIns_addr request by reading four bytes from a byte-wide, fixed-latency external instruction ROM.
- Assembles the bytes little-endian and returns the word on exIns_in with a one-cycle exIns_valid pulse.
- Holds a one-entry last-word buffer so a repeated fetch of the same address returns in one cycle.

Parameters:
- ROM_AW, 12: external ROM byte-address width; legal word range is exIns_addr < 2**ROM_AW.
- ROM_LAT, 2: cycles from rom_en high to rom_rdata valid; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- exIns_ren  in  1  fetch request from core; level, held until exIns_valid.
- exIns_addr  in  32  fetch byte address; bits [1:0] ignored.
- exIns_valid  out  1  one-cycle pulse, exIns_in valid.
- exIns_in  out  32  fetched instruction word.
- fetch_err  out  1  one-cycle pulse coincident with exIns_valid when the address is out of range.
- flush  in  1  invalidates the last-word buffer.
- rom_en  out  1  one-cycle byte read strobe.
- rom_addr  out  ROM_AW  byte address, valid while rom_en = 1.
- rom_rdata  in  8  byte returned exactly ROM_LAT cycles after rom_en.

Behaviour:
- Reset (rst = 1 at clk edge) forces:
  - State IDLE.
  - exIns_valid = 0, fetch_err = 0, rom_en = 0.
  - exIns_in = 0, rom_addr = 0.
  - Buffer tag invalid, byte_idx = 0.
- Reset mid-fetch aborts the fetch; no exIns_valid is issued. A late rom_rdata is ignored.
- State machine (states in shared package):
  - IDLE
    - If ren = 0: stay.
    - If addr[31:ROM_AW] != 0: go ERR.
    - Else if tag valid, tag == addr[31:2] and flush = 0: go HIT.
    - Else: latch addr[31:2], set byte_idx = 0, go ISSUE.
  - ISSUE
    - rom_en = 1, rom_addr = {addr_q[ROM_AW-1:2], byte_idx}.
    - Load wait counter with ROM_LAT; go WAIT.
  - WAIT
    - Decrement the counter. When the counter reaches 0, capture rom_rdata into word byte lane byte_idx (little-endian: byte 0 -> [7:0]).
    - If byte_idx == 3: go DONE. Else: byte_idx + 1, go ISSUE.
  - DONE
    - exIns_valid = 1, exIns_in = assembled word.
    - Tag <= addr_q, tag valid <= 1, unless a flush occurred during this fetch (then tag valid = 0).
    - Go IDLE.
  - HIT
    - exIns_valid = 1, exIns_in = buffered word. Go IDLE.
  - ERR
    - exIns_valid = 1, fetch_err = 1, exIns_in = 32'h00000013 (NOP). Tag untouched. Go IDLE.
- Latency, measured from the IDLE cycle T that samples the request:
  - Miss: exIns_valid at T + 4*ROM_LAT + 5 (13 cycles for ROM_LAT = 2).
  - Hit or error: exIns_valid at T + 1.
- Handshake:
  - ren is ignored outside IDLE.
  - The core must deassert ren or change address in the cycle after exIns_valid.
  - A ren still held with the same address in the following IDLE cycle is served as a hit.
- exIns_in holds its last value between valid pulses.
- Outputs are registered: no combinational path from exIns_ren or exIns_addr to any output.
- flush:
  - In IDLE with a matching request in the same cycle: flush wins, the request is treated as a miss.
  - During ISSUE or WAIT: the fetch completes and returns data, but the result is not cached.
- Only one rom_en is outstanding at any time.
- rom_addr wraps within a word only: byte_idx is 2 bits, never carries into bit 2.

Decomposition:
- exins_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE, HIT, ERR);
  - NOP constant 32'h00000013;
  - byte-index typedef (2 bits).
- One sub-module, exins_word_asm: 4-byte lane register with byte-enable write by index and a clear input. The FSM, counter and tag stay in the top module.

Test Plan:
- Miss fetch: ROM bytes 0x000..0x003 = 93,00,10,00; ren at addr 0x0 -> rom_en pulses at rom_addr 0,1,2,3 spaced ROM_LAT+1 apart; exIns_valid after 13 cycles with exIns_in = 32'h00100093.
- Hit: repeat addr 0x2 (same word) immediately after the previous fetch -> valid next cycle with 32'h00100093, no rom_en.
- Flush: assert flush with the request for addr 0x0 -> full 13-cycle miss path; a subsequent fetch of addr 0x0 is a hit again.
- Out of range: addr 0x00001000 with ROM_AW = 12 -> valid and fetch_err at T+1, exIns_in = 32'h00000013, no rom_en.
- Reset mid-fetch: rst during WAIT of byte 2 -> all outputs 0 next cycle, no valid pulse; a new fetch of addr 0x4 returns the correct word 13 cycles after its request.
- Back-to-back misses at addrs 0x4 and 0x8 -> two valid pulses; the second arrives exactly 13 cycles after its request is sampled in IDLE.
